// File: rtl/fb_wr_sched_if.sv
// rtl/fb_wr_sched_if.sv - bus bundle between pixel/overlay/clear sources and the frame-buffer write scheduler
//
// Purpose: groups every handshake, control and BRAM-write signal of fb_wr_sched.
// Signals:
//   vp_valid/vp_data/vp_sof/vp_ready        video pixel stream (sof marks pixel 0 of a frame)
//   ov_valid/ov_addr/ov_data/ov_ready       addressed overlay writes
//   ov_err                                  pulse: accepted overlay address out of frame
//   clear_req/clear_val/clear_busy          full-frame clear control
//   frame_done                              pulse with the write of the last frame pixel
//   bram_wr/bram_addr/bram_data             BRAM write port
// Modports: master = source/sink side, slave = scheduler side.
interface fb_wr_sched_if #(
    parameter int DW = 8,
    parameter int AW = 19
);
    logic          vp_valid;
    logic [DW-1:0] vp_data;
    logic          vp_sof;
    logic          vp_ready;
    logic          ov_valid;
    logic [AW-1:0] ov_addr;
    logic [DW-1:0] ov_data;
    logic          ov_ready;
    logic          ov_err;
    logic          clear_req;
    logic [DW-1:0] clear_val;
    logic          clear_busy;
    logic          frame_done;
    logic          bram_wr;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_data;

    modport master (
        output vp_valid, vp_data, vp_sof, ov_valid, ov_addr, ov_data, clear_req, clear_val,
        input  vp_ready, ov_ready, ov_err, clear_busy, frame_done, bram_wr, bram_addr, bram_data
    );

    modport slave (
        input  vp_valid, vp_data, vp_sof, ov_valid, ov_addr, ov_data, clear_req, clear_val,
        output vp_ready, ov_ready, ov_err, clear_busy, frame_done, bram_wr, bram_addr, bram_data
    );
endinterface

// File: rtl/fb_wr_sched.sv
// rtl/fb_wr_sched.sv - frame-buffer BRAM write-port scheduler (video, overlay, full-frame clear)
//
// Purpose: shares one BRAM write port between an auto-addressed video pixel stream and an
// addressed overlay stream (round-robin when both request), and sequences a full-frame clear.
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   fb_wr_sched_if.slave: video/overlay handshakes, clear control, BRAM write port
// Writes are registered: a handshake in cycle N appears on the BRAM port in cycle N+1.
module fb_wr_sched #(
    parameter int DW           = 8,
    parameter int AW           = 19,
    parameter int FRAME_PIXELS = 307200
) (
    input  logic         clk,
    input  logic         rst,
    fb_wr_sched_if.slave bus
);
    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_PIXELS - 1);

    typedef enum logic {
        RUN,
        CLEAR
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] vp_cnt;
    logic          rr_ov;       // 1: overlay wins the next tie
    logic          vp_ready;
    logic          ov_ready;
    logic          bram_wr;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_data;
    logic          frame_done;
    logic          ov_err;
    logic          vp_hs;
    logic          ov_hs;
    logic          ov_in_range;

    always_comb begin
        state_d  = state_q;
        vp_ready = 1'b0;
        ov_ready = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.clear_req) begin
                    state_d = CLEAR;
                end else if (!rst) begin
                    // A source is ready whenever the other is idle or loses the tie.
                    vp_ready = !bus.ov_valid || !rr_ov;
                    ov_ready = !bus.vp_valid || rr_ov;
                end
            end
            CLEAR: begin
                // While clearing, bram_addr is the address currently being written.
                if (bram_addr == LAST_ADDR) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign vp_hs       = bus.vp_valid && vp_ready;
    assign ov_hs       = bus.ov_valid && ov_ready;
    assign ov_in_range = (bus.ov_addr <= LAST_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            vp_cnt     <= '0;
            rr_ov      <= 1'b0;
            bram_wr    <= 1'b0;
            bram_addr  <= '0;
            bram_data  <= '0;
            frame_done <= 1'b0;
            ov_err     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bram_wr    <= 1'b0;
            frame_done <= 1'b0;
            ov_err     <= 1'b0;
            case (state_q)
                RUN: begin
                    if (bus.clear_req) begin
                        // First clear write is issued straight from the entry edge so that the
                        // CLEAR state spans exactly FRAME_PIXELS cycles; bram_data holds the fill.
                        bram_wr   <= 1'b1;
                        bram_addr <= '0;
                        bram_data <= bus.clear_val;
                        vp_cnt    <= '0;
                        rr_ov     <= 1'b0;
                    end else begin
                        if (bus.vp_valid && bus.ov_valid) begin
                            rr_ov <= !rr_ov;
                        end
                        // vp_hs and ov_hs are mutually exclusive by construction of the readies.
                        if (vp_hs) begin
                            bram_wr   <= 1'b1;
                            bram_data <= bus.vp_data;
                            if (bus.vp_sof) begin
                                bram_addr <= '0;
                                vp_cnt    <= AW'(1);
                            end else begin
                                bram_addr  <= vp_cnt;
                                frame_done <= (vp_cnt == LAST_ADDR);
                                vp_cnt     <= (vp_cnt == LAST_ADDR) ? '0 : vp_cnt + AW'(1);
                            end
                        end else if (ov_hs) begin
                            if (ov_in_range) begin
                                bram_wr   <= 1'b1;
                                bram_addr <= bus.ov_addr;
                                bram_data <= bus.ov_data;
                            end else begin
                                ov_err <= 1'b1;
                            end
                        end
                    end
                end
                CLEAR: begin
                    if (bram_addr != LAST_ADDR) begin
                        bram_wr   <= 1'b1;
                        bram_addr <= bram_addr + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.vp_ready   = vp_ready;
    assign bus.ov_ready   = ov_ready;
    assign bus.ov_err     = ov_err;
    assign bus.clear_busy = (state_q == CLEAR);
    assign bus.frame_done = frame_done;
    assign bus.bram_wr    = bram_wr;
    assign bus.bram_addr  = bram_addr;
    assign bus.bram_data  = bram_data;
endmodule

// File: tb/tb_fb_wr_sched.sv
// tb/tb_fb_wr_sched.sv - self-checking bench for fb_wr_sched with a write scoreboard
module tb_fb_wr_sched;
    localparam int DW = 8;
    localparam int AW = 19;
    localparam int FP = 1200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fb_wr_sched_if #(.DW(DW), .AW(AW)) bus ();

    fb_wr_sched #(.DW(DW), .AW(AW), .FRAME_PIXELS(FP)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
        bit            fd;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   m_cnt = 0;
    int   err_cyc = -1;
    int   fd_seen = 0;
    bit   vp_g;
    bit   ov_g;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                total++;
                if (bus.ov_err !== 1'(err_cyc == cyc)) begin
                    bad++;
                    $display("FAIL ov_err cyc=%0d got=%b exp=%b", cyc, bus.ov_err, err_cyc == cyc);
                end
                if (bus.frame_done) fd_seen++;
                if (bus.bram_wr) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_write cyc=%0d addr=%0d data=%h", cyc, bus.bram_addr, bus.bram_data);
                    end else begin
                        e = sb.pop_front();
                        if (bus.bram_addr !== e.addr || bus.bram_data !== e.data ||
                            cyc != e.cyc || bus.frame_done !== e.fd) begin
                            bad++;
                            $display("FAIL bram_write got addr=%0d data=%h cyc=%0d fd=%b exp addr=%0d data=%h cyc=%0d fd=%b",
                                     bus.bram_addr, bus.bram_data, cyc, bus.frame_done, e.addr, e.data, e.cyc, e.fd);
                        end
                    end
                end else if (bus.frame_done) begin
                    total++;
                    bad++;
                    $display("FAIL stray_frame_done cyc=%0d got=1 exp=0", cyc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    task automatic idle_inputs();
        bus.vp_valid  = 1'b0;
        bus.vp_data   = '0;
        bus.vp_sof    = 1'b0;
        bus.ov_valid  = 1'b0;
        bus.ov_addr   = '0;
        bus.ov_data   = '0;
        bus.clear_req = 1'b0;
        bus.clear_val = '0;
    endtask

    // Called at a negedge: records handshakes and pushes the expected writes.
    task automatic sample();
        exp_t e;
        vp_g = bus.vp_valid && bus.vp_ready;
        ov_g = bus.ov_valid && bus.ov_ready;
        if (vp_g) begin
            if (bus.vp_sof) begin
                e.addr = '0;
                m_cnt  = 1;
            end else begin
                e.addr = AW'(m_cnt);
                m_cnt  = (m_cnt == FP - 1) ? 0 : m_cnt + 1;
            end
            e.fd   = (e.addr == AW'(FP - 1));
            e.data = bus.vp_data;
            e.cyc  = cyc + 1;
            sb.push_back(e);
        end
        if (ov_g) begin
            if (bus.ov_addr < FP) begin
                e.addr = bus.ov_addr;
                e.data = bus.ov_data;
                e.cyc  = cyc + 1;
                e.fd   = 1'b0;
                sb.push_back(e);
            end else begin
                err_cyc = cyc + 1;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic push_clear(input logic [DW-1:0] val);
        exp_t e;
        for (int i = 0; i < FP; i++) begin
            e.addr = AW'(i);
            e.data = val;
            e.cyc  = cyc + 1 + i;
            e.fd   = 1'b0;
            sb.push_back(e);
        end
        m_cnt = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        m_cnt   = 0;
        err_cyc = -1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 10 && sb.size() > 0; i++) step();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_drain pending=%0d exp=0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total += 7;
        if (bus.bram_wr !== 1'b0)    begin bad++; $display("FAIL reset_bram_wr got=%b exp=0", bus.bram_wr); end
        if (bus.bram_addr !== '0)    begin bad++; $display("FAIL reset_bram_addr got=%0d exp=0", bus.bram_addr); end
        if (bus.bram_data !== '0)    begin bad++; $display("FAIL reset_bram_data got=%h exp=0", bus.bram_data); end
        if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b exp=0", bus.frame_done); end
        if (bus.ov_err !== 1'b0)     begin bad++; $display("FAIL reset_ov_err got=%b exp=0", bus.ov_err); end
        if (bus.clear_busy !== 1'b0) begin bad++; $display("FAIL reset_clear_busy got=%b exp=0", bus.clear_busy); end
        if (bus.vp_ready !== 1'b0 || bus.ov_ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready got=%b%b exp=00", bus.vp_ready, bus.ov_ready);
        end
        do_reset();
    endtask

    task automatic test_video();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.vp_valid = 1'b1;
            bus.vp_data  = DW'(8'h11 + i);
            bus.vp_sof   = (i == 0);
            step();
            total++;
            if (!vp_g) begin bad++; $display("FAIL video_grant px=%0d got=0 exp=1", i); end
        end
        idle_inputs();
        drain("video");
    endtask

    task automatic test_frame();
        int fd0;
        int misses;
        do_reset();
        fd0    = fd_seen;
        misses = 0;
        for (int i = 0; i < FP + 2; i++) begin
            bus.vp_valid = 1'b1;
            bus.vp_sof   = 1'b0;
            bus.vp_data  = DW'(i);
            step();
            if (!vp_g) misses++;
        end
        idle_inputs();
        drain("frame");
        total += 2;
        if (misses != 0) begin bad++; $display("FAIL frame_grants missed=%0d exp=0", misses); end
        if (fd_seen - fd0 != 1) begin bad++; $display("FAIL frame_done_count got=%0d exp=1", fd_seen - fd0); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] vdata;
        do_reset();
        vdata        = 8'h20;
        bus.vp_valid = 1'b1;
        bus.ov_valid = 1'b1;
        bus.ov_addr  = AW'(100);
        bus.ov_data  = 8'hAA;
        for (int i = 0; i < 6; i++) begin
            bus.vp_data = vdata;
            step();
            total++;
            if (vp_g !== (i % 2 == 0) || ov_g !== (i % 2 == 1)) begin
                bad++;
                $display("FAIL rr_grant slot=%0d got v=%b o=%b exp v=%b o=%b", i, vp_g, ov_g, i % 2 == 0, i % 2 == 1);
            end
            if (vp_g) vdata = vdata + 8'h01;
        end
        idle_inputs();
        drain("rr");
    endtask

    task automatic test_ov_err();
        do_reset();
        bus.vp_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.vp_data = DW'(8'h30 + i);
            step();
        end
        bus.vp_valid = 1'b0;
        bus.ov_valid = 1'b1;
        bus.ov_addr  = AW'(FP);
        bus.ov_data  = 8'hEE;
        step();
        total++;
        if (!ov_g) begin bad++; $display("FAIL ov_err_ready got=0 exp=1"); end
        bus.ov_valid = 1'b0;
        step();
        bus.vp_valid = 1'b1;
        bus.vp_data  = 8'h32;
        step();
        idle_inputs();
        drain("ov_err");
    endtask

    task automatic test_clear();
        int  busy_n;
        bit  rdy_bad;
        do_reset();
        bus.vp_valid  = 1'b1;
        bus.vp_data   = 8'h44;
        bus.ov_valid  = 1'b1;
        bus.ov_addr   = AW'(7);
        bus.ov_data   = 8'h33;
        bus.clear_req = 1'b1;
        bus.clear_val = 8'h5A;
        @(negedge clk);
        total++;
        if (bus.vp_ready !== 1'b0 || bus.ov_ready !== 1'b0) begin
            bad++; $display("FAIL clear_req_ready got=%b%b exp=00", bus.vp_ready, bus.ov_ready);
        end
        push_clear(8'h5A);
        @(posedge clk);
        #1;
        bus.clear_req = 1'b0;
        bus.clear_val = 8'h00;
        busy_n  = 0;
        rdy_bad = 1'b0;
        for (int i = 0; i < FP + 20; i++) begin
            @(negedge clk);
            if (!bus.clear_busy) break;
            busy_n++;
            if (bus.vp_ready || bus.ov_ready) rdy_bad = 1'b1;
            @(posedge clk);
            #1;
        end
        sample();
        total += 3;
        if (busy_n != FP) begin bad++; $display("FAIL clear_busy_cycles got=%0d exp=%0d", busy_n, FP); end
        if (rdy_bad) begin bad++; $display("FAIL clear_ready_while_busy got=1 exp=0"); end
        if (!vp_g || ov_g) begin bad++; $display("FAIL clear_resume_grant got v=%b o=%b exp v=1 o=0", vp_g, ov_g); end
        @(posedge clk);
        #1;
        idle_inputs();
        drain("clear");
    endtask

    task automatic test_reset_mid_clear();
        bit found;
        do_reset();
        bus.clear_req = 1'b1;
        bus.clear_val = 8'h77;
        @(negedge clk);
        push_clear(8'h77);
        @(posedge clk);
        #1;
        bus.clear_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < FP + 10; i++) begin
            @(posedge clk);
            #3;
            if (bus.bram_wr && bus.bram_addr == AW'(1000)) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!found) begin bad++; $display("FAIL mid_clear_addr1000 got=0 exp=1"); end
        rst = 1'b1;
        @(posedge clk);
        #3;
        total += 2;
        if (bus.bram_wr !== 1'b0)    begin bad++; $display("FAIL mid_clear_rst_wr got=%b exp=0", bus.bram_wr); end
        if (bus.clear_busy !== 1'b0) begin bad++; $display("FAIL mid_clear_rst_busy got=%b exp=0", bus.clear_busy); end
        sb.delete();
        m_cnt   = 0;
        err_cyc = -1;
        rst     = 1'b0;
        bus.vp_valid = 1'b1;
        bus.vp_data  = 8'h42;
        step();
        total++;
        if (!vp_g) begin bad++; $display("FAIL mid_clear_resume_grant got=0 exp=1"); end
        idle_inputs();
        drain("mid_clear");
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_video();
        test_frame();
        test_back_to_back();
        test_ov_err();
        test_clear();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
